// File: rtl/usr_pkg.sv
// Shared types for the parametrised universal shift register.
// Mode and state encodings used by the top level and the barrel unit.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    LOAD = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    ASR  = 3'd6,
    SER  = 3'd7
  } usr_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_barrel.sv
// Combinational rotate / arithmetic-shift unit.
// Rotates wrap modulo WIDTH; ASR saturates to the sign bit.
module usr_barrel
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  usr_mode_e        op,
  output logic [WIDTH-1:0] result
);

  localparam logic [AMT_W:0] LP_W = WIDTH[AMT_W:0];

  logic [AMT_W:0]   w_sh;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_asr;

  // Rotate distance reduced modulo WIDTH for non power-of-two widths.
  assign w_sh  = {1'b0, amt} % LP_W;

  assign w_ror = (data >> w_sh) | (data << (WIDTH - int'(w_sh)));
  assign w_rol = (data << w_sh) | (data >> (WIDTH - int'(w_sh)));
  assign w_asr = $signed(data) >>> amt;

  // Select the requested operation; other modes pass data through.
  always_comb begin
    result = data;
    unique case (op)
      ROR:     result = w_ror;
      ROL:     result = w_rol;
      ASR:     result = w_asr;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/usr_shift_reg_p.sv
// Parametrised universal shift register with barrel ops and a
// self-timed serializer; all state advances on the falling edge.
module usr_shift_reg_p
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       m,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] LP_CNT_INIT = AMT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_par;
  logic [AMT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  usr_state_e       r_state;

  usr_mode_e        w_mode;
  logic [WIDTH-1:0] w_barrel;

  assign w_mode = usr_mode_e'(m);

  usr_barrel #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_barrel (
    .data   (r_par),
    .amt    (amt),
    .op     (w_mode),
    .result (w_barrel)
  );

  // Register, serialize counter and mode FSM; en low freezes everything.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= IDLE;
    end else if (en) begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          unique case (w_mode)
            HOLD: r_par <= r_par;
            SHR:  r_par <= {ser_in_msb, r_par[WIDTH-1:1]};
            SHL:  r_par <= {r_par[WIDTH-2:0], ser_in_lsb};
            LOAD: r_par <= par_in;
            ROR:  r_par <= w_barrel;
            ROL:  r_par <= w_barrel;
            ASR:  r_par <= w_barrel;
            SER: begin
              r_par   <= par_in;
              r_cnt   <= LP_CNT_INIT;
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end
            default: r_par <= r_par;
          endcase
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_par <= {ser_in_msb, r_par[WIDTH-1:1]};
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign par_out = r_par;
  assign ser_out = r_par[0];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_usr_shift_reg_p.sv
// Directed + random bench for usr_shift_reg_p (WIDTH=8).
// Reference model uses plain arithmetic and a captured bit frame.
module tb_usr_shift_reg_p;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    m;
  logic [AW-1:0] amt;
  logic          ser_in_msb;
  logic          ser_in_lsb;
  logic [W-1:0]  par_in;
  logic [W-1:0]  par_out;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] mp;
  bit           mbusy;
  bit           mdone;
  int           mleft;
  bit           fr [W];

  always #5 clk = ~clk;

  usr_shift_reg_p #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .m          (m),
    .amt        (amt),
    .ser_in_msb (ser_in_msb),
    .ser_in_lsb (ser_in_lsb),
    .par_in     (par_in),
    .par_out    (par_out),
    .ser_out    (ser_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] f_ror(input logic [W-1:0] d, input int a);
    int s;
    int v;
    int r;
    s = a % W;
    v = int'(d);
    r = (v >> s) | (v << (W - s));
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] f_rol(input logic [W-1:0] d, input int a);
    int s;
    int v;
    int r;
    s = a % W;
    v = int'(d);
    r = (v << s) | (v >> (W - s));
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] f_asr(input logic [W-1:0] d, input int a);
    int sv;
    int r;
    sv = int'(d);
    if (d[W-1]) sv = sv - (1 << W);
    r = sv >>> a;
    return r[W-1:0];
  endfunction

  task automatic model_reset();
    mp    = '0;
    mbusy = 0;
    mdone = 0;
    mleft = 0;
  endtask

  task automatic model_edge();
    if (!en) return;
    mdone = 0;
    if (mbusy) begin
      if (mleft > 1) begin
        mp = (mp >> 1) | (W'(ser_in_msb) << (W - 1));
        mleft--;
      end else begin
        mbusy = 0;
        mdone = 1;
        mleft = 0;
      end
    end else begin
      case (int'(m))
        1: mp = (mp >> 1) | (W'(ser_in_msb) << (W - 1));
        2: mp = (mp << 1) | W'(ser_in_lsb);
        3: mp = par_in;
        4: mp = f_ror(mp, int'(amt));
        5: mp = f_rol(mp, int'(amt));
        6: mp = f_asr(mp, int'(amt));
        7: begin
          mp    = par_in;
          mbusy = 1;
          mleft = W;
          for (int i = 0; i < W; i++) fr[i] = par_in[i];
        end
        default: mp = mp;
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    #1;
    chk("par_out", par_out, mp);
    chk("busy", busy, mbusy);
    chk("done", done, mdone);
    chk("ser_out", ser_out, mp[0]);
    if (mbusy) chk("ser_bit", ser_out, fr[W - mleft]);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_par"}, par_out, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1;
    m = 3'd3;
    par_in = v;
    step();
  endtask

  initial begin
    int nb;
    int guard;
    logic [W-1:0] got;

    rst_n = 1'b0;
    en = 1'b1;
    m = 3'd0;
    amt = '0;
    ser_in_msb = 1'b0;
    ser_in_lsb = 1'b0;
    par_in = '0;
    model_reset();
    #3;
    chk("rst_par", par_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    load(8'h5A);
    async_reset_check("rst_mid");

    load(8'hAB);
    chk("load_ab", par_out, 8'hAB);

    m = 3'd1; ser_in_msb = 1'b1; step();
    chk("shr", par_out, 8'hD5);
    load(8'hAB);
    m = 3'd2; ser_in_lsb = 1'b0; step();
    chk("shl", par_out, 8'h56);
    m = 3'd0;
    for (int i = 0; i < 5; i++) step();
    chk("hold", par_out, 8'h56);

    load(8'hAB);
    m = 3'd4; amt = 3'd3; step();
    chk("ror3", par_out, 8'h75);
    load(8'hAB);
    m = 3'd5; amt = 3'd3; step();
    chk("rol3", par_out, 8'h5D);
    load(8'hAB);
    m = 3'd6; amt = 3'd2; step();
    chk("asr2", par_out, 8'hEA);
    load(8'hAB);
    m = 3'd6; amt = 3'd0; step();
    chk("asr0", par_out, 8'hAB);

    // Serialize 0xA5 with random mode noise while busy
    ser_in_msb = 1'b0;
    m = 3'd7; par_in = 8'hA5; step();
    nb = 0;
    got = '0;
    while (busy && nb < 20) begin
      if (nb < W) got[nb] = ser_out;
      m = 3'($urandom_range(0, 7));
      amt = 3'($urandom);
      step();
      nb++;
    end
    chk("ser_len", nb, 8);
    chk("ser_bits", got, 8'hA5);
    chk("ser_done", done, 1'b1);
    chk("ser_final", par_out, 8'h01);
    m = 3'd0; step();
    chk("done_pulse", done, 1'b0);

    // Stalled frame, then back-to-back frame on the done cycle
    m = 3'd7; par_in = 8'h3C; step();
    nb = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 30) begin
      en = (guard >= 3 && guard < 6) ? 1'b0 : 1'b1;
      m = 3'($urandom_range(0, 7));
      step();
      if (busy) nb++;
      guard++;
    end
    en = 1'b1;
    chk("stall_len", nb, 11);
    chk("stall_done", done, 1'b1);
    m = 3'd7; par_in = 8'hC3; step();
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_par", par_out, 8'hC3);
    nb = 1;
    guard = 0;
    while (busy && guard < 30) begin
      m = 3'($urandom_range(0, 6));
      step();
      if (busy) nb++;
      guard++;
    end
    chk("b2b_len", nb, 8);

    // Reset in the middle of a frame
    m = 3'd7; par_in = 8'h96; step();
    for (int i = 0; i < 4; i++) step();
    async_reset_check("rst_ser");
    m = 3'd0;
    for (int i = 0; i < 10; i++) step();
    load(8'h3E);
    chk("post_rst_load", par_out, 8'h3E);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      m = 3'($urandom_range(0, 7));
      amt = 3'($urandom);
      ser_in_msb = 1'($urandom);
      ser_in_lsb = 1'($urandom);
      par_in = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usr_shift_reg_p.md
Name: usr_shift_reg_p

Overview:
- Parametrised universal shift register, successor to the fixed 8-bit four-mode unit.
- Adds to the hold / shift-right / shift-left / parallel-load modes:
  - rotate-right and rotate-left by a variable amount;
  - arithmetic shift right by a variable amount;
  - a self-timed serialize mode with busy/done handshake.
- Sits between parallel datapaths and serial links or test benches in the same design family.

Parameters:
- WIDTH, 8, register width in bits. Legal range is WIDTH >= 2.
- AMT_W, $clog2(WIDTH), width of the shift-amount input.

Ports:
- clk  in  1  clock. All state updates on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  update enable. When low, all state holds, including serialize progress.
- m  in  3  mode select (see Behaviour).
- amt  in  AMT_W  shift/rotate amount for modes 4-6.
- ser_in_msb  in  1  serial bit entering the MSB on right shift and serialize.
- ser_in_lsb  in  1  serial bit entering the LSB on left shift.
- par_in  in  WIDTH  parallel load data.
- par_out  out  WIDTH  register contents (registered).
- ser_out  out  1  par_out[0] (combinational from register).
- busy  out  1  high while serialize is in progress (registered).
- done  out  1  one-cycle pulse when serialize completes (registered).

Behaviour:
- Reset (rst_n low, asynchronous): par_out=0, busy=0, done=0, count=0, FSM=IDLE. Reset mid-serialize aborts cleanly with no done pulse.
- done defaults to 0 on every enabled edge unless set below. When en is low, done holds its value.
- IDLE state, en=1, action by m:
  - 0 HOLD: par_out unchanged.
  - 1 SHR: par_out <= {ser_in_msb, par_out[WIDTH-1:1]}.
  - 2 SHL: par_out <= {par_out[WIDTH-2:0], ser_in_lsb}.
  - 3 LOAD: par_out <= par_in.
  - 4 ROR: rotate right by amt mod WIDTH.
  - 5 ROL: rotate left by amt mod WIDTH.
  - 6 ASR: arithmetic shift right by amt. The sign bit is replicated. amt >= WIDTH gives all bits equal to the sign. amt=0 leaves par_out unchanged.
  - 7 SER: par_out <= par_in, count <= WIDTH-1, busy <= 1, FSM -> SHIFT.
- SHIFT state, en=1:
  - m and amt are ignored.
  - If count != 0: par_out <= {ser_in_msb, par_out[WIDTH-1:1]}, count <= count-1.
  - If count == 0: par_out holds, busy <= 0, done <= 1, FSM -> IDLE.
- Serialize timing:
  - busy is high for exactly WIDTH enabled cycles.
  - In the k-th busy cycle (k = 0..WIDTH-1), ser_out = par_in[k] as captured at SER entry.
  - A new SER issued in the cycle done is high is accepted, giving back-to-back frames with no gap.
- en low in SHIFT stretches the frame. busy stays high and the count freezes.
- Latency: every mode result is visible on par_out one falling edge after sampling.
- All outputs are X-free after reset. No default X assignment.

Decomposition:
- Package usr_pkg holds:
  - typedef enum logic [2:0] usr_mode_e {HOLD, SHR, SHL, LOAD, ROR, ROL, ASR, SER};
  - typedef enum logic usr_state_e {IDLE, SHIFT}.
- One combinational sub-module, usr_barrel (WIDTH, AMT_W). Inputs: data, amt, op {ROR, ROL, ASR}. Output: result.
- The top level owns the register, counter and FSM.

Test Plan (WIDTH=8):
- Reset and load:
  - Assert rst_n=0 mid-run -> par_out=0x00, busy=0, done=0 immediately, without a clock edge.
  - LOAD 0xAB -> par_out=0xAB after one falling edge.
- Single-bit shifts from 0xAB:
  - SHR with ser_in_msb=1 -> 0xD5.
  - Reload, then SHL with ser_in_lsb=0 -> 0x56.
  - HOLD for 5 cycles -> stays 0x56.
- Barrel ops from 0xAB:
  - ROR amt=3 -> 0x75.
  - Reload, ROL amt=3 -> 0x5D.
  - Reload, ASR amt=2 -> 0xEA.
  - Reload, ASR amt=0 -> 0xAB.
- Serialize 0xA5 with ser_in_msb=0:
  - ser_out sequence 1,0,1,0,0,1,0,1 over 8 busy cycles.
  - done pulses one cycle, final par_out=0x01.
  - m toggled randomly during busy has no effect.
- Stall and back-to-back:
  - SER 0x3C, drop en for 3 cycles mid-frame -> busy spans 11 cycles, bit order preserved.
  - Issue SER 0xC3 on the done cycle -> second frame starts without an idle gap.
- Reset mid-serialize:
  - rst_n low at busy cycle 4 -> busy=0, done never pulses.
  - After release, LOAD works normally.
